md5_multi_lane_engine: RTL and testbench
========================================

// Module: md5_multi_lane_engine
// PURPOSE
//  Parametrised multi-lane successor of the single-core MD5 search engine.
//  Dispatches padded 512-bit blocks round-robin to NUM_LANES md5_top cores.
//  Each lane keeps its own copy of the block header.
//  Digests retire strictly in dispatch order. The first (lowest-sequence) digest
//  with zero_nibbles leading zero hex digits is reported, then the engine halts.
//  Sits between the candidate-block generator and the answer formatter.
// PARAMETERS
//  NUM_LANES     4    parallel md5_top cores; power of two, 1..16
//  BLOCK_WIDTH   512  input block width (bits)
//  HEADER_WIDTH  128  MSBs of the block captured and reported with a match
//  SEQ_WIDTH     32   block sequence counter width; wraps modulo 2**SEQ_WIDTH
// PORTS
//  clk              in   1             single clock domain
//  reset            in   1             synchronous, active-low (0 = reset)
//  zero_nibbles     in   6             leading zero nibbles required, 0..32; values >32 act as 32
//  restart          in   1             pulse: clear done/counters and resume search
//  md5_block_ready  out  1             engine accepts md5_block_data this cycle
//  md5_block_valid  in   1             upstream block valid
//  md5_block_data   in   BLOCK_WIDTH   padded MD5 block; header = [BLOCK_WIDTH-1-:HEADER_WIDTH]
//  result_valid     out  1             one-cycle pulse: match found
//  result_data      out  HEADER_WIDTH  header of the matching block
//  result_seq       out  SEQ_WIDTH     dispatch sequence number of the matching block
//  done             out  1             high from the match until restart completes
// BEHAVIOUR
//  - Reset (reset==0 at clk edge): disp_ptr=ret_ptr=0, seq=0, outstanding=0, all lane flags clear.
//    Outputs during and after reset: ready=0, result_valid=0, result_data=0, result_seq=0, done=0.
//  - Lane L is free when its core is ready, no digest is pending and no block is in flight.
//  - ready = !done && !restart_pending && lane[disp_ptr] free. Ready depends only on state, never on valid.
//  - Accept (ready && valid):
//    - lane[disp_ptr] takes the block, captures the header, stores seq.
//    - disp_ptr++ mod NUM_LANES, seq++, outstanding++.
//  - Dispatch is strict round-robin. A busy lane stalls the input even when other lanes are free.
//  - Lane digest_valid (1-cycle pulse) latches hit = top 4*zero_nibbles digest bits all zero.
//    It also sets that lane's pending flag. zero_nibbles==0 makes every digest a hit.
//  - Retire: when lane[ret_ptr] has pending set, clear it, ret_ptr++ mod NUM_LANES, outstanding--.
//    - hit && !done: next cycle result_valid=1 with that lane's header/seq, and done=1.
//    - Otherwise no output.
//    - At most one retire per cycle.
//  - Latency: result_valid rises 2 clk after the digest_valid pulse, if that block is the oldest outstanding.
//    Younger digests wait in their lane until ret_ptr reaches them.
//  - After done, in-flight blocks still drain and retire silently. Later hits are discarded.
//  - result_data/result_seq hold their value until the next match or reset.
//  - restart sets restart_pending (ready=0).
//    When outstanding==0: pointers, seq and done clear, then restart_pending clears.
//    restart while already idle completes in 1 cycle.
//  - Accept and retire in the same cycle: outstanding unchanged.
//    Same-lane digest latch and retire never coincide (latch first, retire next cycle).
//  - zero_nibbles is quasi-static. Change it only when outstanding==0; otherwise hits are undefined.
//  - seq wraps 2**SEQ_WIDTH-1 -> 0 with no flag. Ordering is unaffected because retirement is by ret_ptr.
// STRUCTURE
//  - Package md5_multi_pkg:
//    - digest_t (128b), header_t, seq_t, lane_idx_t.
//    - DIGEST_WIDTH=128.
//    - function nibbles_zero(digest_t, logic [5:0]) -> logic.
//  - Sub-module md5_lane: wraps md5_top and holds:
//    - header register, seq register, in-flight/pending/hit flags;
//    - free, take, pop handshake.
//  - Top: generate loop of md5_lane, dispatch/retire pointers, outstanding counter, restart FSM.
//  - Restart FSM states: RUN -> DRAIN (restart seen, outstanding>0) -> RUN.
// TESTING
//  - Bench model: md5_top with a per-block random latency of 60..80 cycles.
//  - Reset: hold reset=0 for 3 cycles with valid=1 -> ready, result_valid and done stay 0; no accept.
//  - NUM_LANES=4, zero_nibbles=5:
//    - Feed blocks "abcdef609043".."abcdef609050".
//    - Expect a single result_valid, with header "abcdef609043" (seq 0) and done=1.
//  - Out-of-order completion: blocks seq 0..3, lane 2 completes first and hits.
//    - Expect result_valid only after seq 0,1 retire; result_seq=2.
//  - Two hits (seq 1 and 3) -> one result_valid, result_seq=1; seq 3 is discarded; all lanes drain.
//  - restart while outstanding=3 -> ready stays 0 until drained.
//    Then seq restarts at 0 and the next accept lands on lane 0.
//  - zero_nibbles=0 -> first block reported with result_seq=0.
//  - SEQ_WIDTH=4: dispatch 20 blocks with no hit -> seq wraps; ready never deadlocks.

Source files
------------

// File: rtl/md5_multi_pkg.sv
// Shared types and the leading-zero-nibble test for the multi-lane MD5 engine.
package md5_multi_pkg;
    localparam int DIGEST_WIDTH = 128;
    localparam int MAX_NIBBLES  = DIGEST_WIDTH / 4;

    typedef logic [DIGEST_WIDTH-1:0] digest_t;
    typedef logic [127:0]            header_t;
    typedef logic [31:0]             seq_t;
    typedef logic [3:0]              lane_idx_t;

    // True when the top 'count' hex digits of the digest are zero.
    // A count above 32 naturally saturates because every nibble is then inspected.
    function automatic logic nibbles_zero(input digest_t digest, input logic [5:0] count);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < MAX_NIBBLES; i++) begin
            if ((i < int'(count)) && (digest[DIGEST_WIDTH-1-4*i -: 4] != 4'h0)) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction
endpackage

// File: rtl/md5_multi_lane_engine_if.sv
// Block-input and result-output bundle of the multi-lane MD5 engine.
// The slave side is the engine, the master side is the block generator / formatter.
interface md5_multi_lane_engine_if #(
    parameter int BLOCK_WIDTH  = 512,
    parameter int HEADER_WIDTH = 128,
    parameter int SEQ_WIDTH    = 32
);
    logic                    md5_block_ready;
    logic                    md5_block_valid;
    logic [BLOCK_WIDTH-1:0]  md5_block_data;
    logic                    result_valid;
    logic [HEADER_WIDTH-1:0] result_data;
    logic [SEQ_WIDTH-1:0]    result_seq;

    modport master (
        input  md5_block_ready, result_valid, result_data, result_seq,
        output md5_block_valid, md5_block_data
    );

    modport slave (
        output md5_block_ready, result_valid, result_data, result_seq,
        input  md5_block_valid, md5_block_data
    );
endinterface

// File: rtl/md5_lane.sv
// One hashing lane: the core plus the header/sequence it is working on and the
// in-flight / pending / hit bookkeeping used by in-order retirement.
module md5_lane import md5_multi_pkg::*; #(
    parameter int BLOCK_WIDTH  = 512,
    parameter int HEADER_WIDTH = 128,
    parameter int SEQ_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [5:0]              zero_nibbles,
    input  logic                    take,
    input  logic [BLOCK_WIDTH-1:0]  block,
    input  logic [SEQ_WIDTH-1:0]    seq_in,
    input  logic                    pop,
    output logic                    free,
    output logic                    pending,
    output logic                    hit,
    output logic [HEADER_WIDTH-1:0] header,
    output logic [SEQ_WIDTH-1:0]    seq
);
    logic    core_ready;
    logic    digest_valid;
    digest_t digest;
    logic    in_flight;

    md5_top u_core (
        .clk          (clk),
        .reset        (reset),
        .start        (take),
        .block        (block),
        .ready        (core_ready),
        .digest_valid (digest_valid),
        .digest       (digest)
    );

    assign free = core_ready && !pending && !in_flight;

    // Capture block identity on take; latch the hit verdict when the digest arrives.
    always_ff @(posedge clk) begin
        if (!reset) begin
            in_flight <= 1'b0;
            pending   <= 1'b0;
            hit       <= 1'b0;
            header    <= '0;
            seq       <= '0;
        end else begin
            if (take) begin
                in_flight <= 1'b1;
                header    <= block[BLOCK_WIDTH-1 -: HEADER_WIDTH];
                seq       <= seq_in;
            end
            if (digest_valid) begin
                in_flight <= 1'b0;
                pending   <= 1'b1;
                hit       <= nibbles_zero(digest, zero_nibbles);
            end else if (pop) begin
                pending <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/md5_top.sv
// Stand-in for the md5_top hashing core with the same handshake: one block in,
// one digest_valid pulse out after a per-block latency. The digest is taken from
// block[127:0] and the latency (cycles, 0 treated as 1) from block[135:128], so
// lane sequencing can be exercised without the full round pipeline.
module md5_top (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [511:0] block,
    output logic         ready,
    output logic         digest_valid,
    output logic [127:0] digest
);
    logic [7:0] count;
    logic       busy;
    logic       unused_block_bits;

    assign ready             = !busy;
    assign unused_block_bits = ^block[511:136];

    // Down-counter from the block's latency field; terminal count emits the digest pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy         <= 1'b0;
            count        <= 8'd0;
            digest_valid <= 1'b0;
            digest       <= '0;
        end else begin
            digest_valid <= 1'b0;
            if (start && !busy) begin
                busy   <= 1'b1;
                count  <= (block[135:128] == 8'd0) ? 8'd1 : block[135:128];
                digest <= block[127:0];
            end else if (busy) begin
                if (count == 8'd1) begin
                    busy         <= 1'b0;
                    digest_valid <= 1'b1;
                end else begin
                    count <= count - 8'd1;
                end
            end
        end
    end
endmodule

// File: rtl/md5_multi_lane_engine.sv
// Multi-lane MD5 search engine: round-robin dispatch to NUM_LANES cores,
// strictly in-order retirement, first hit reported once, then halt until restart.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | normal dispatch/retire
// ST_DRAIN | restart seen with blocks outstanding; input held off until empty
module md5_multi_lane_engine import md5_multi_pkg::*; #(
    parameter int NUM_LANES    = 4,
    parameter int BLOCK_WIDTH  = 512,
    parameter int HEADER_WIDTH = 128,
    parameter int SEQ_WIDTH    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             zero_nibbles,
    input  logic                   restart,
    output logic                   done,
    md5_multi_lane_engine_if.slave bus
);
    localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int CNT_W = $clog2(NUM_LANES + 1);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [0:0]              state;
    logic [PTR_W-1:0]        disp_ptr;
    logic [PTR_W-1:0]        ret_ptr;
    logic [PTR_W-1:0]        disp_ptr_next;
    logic [PTR_W-1:0]        ret_ptr_next;
    logic [SEQ_WIDTH-1:0]    seq;
    logic [CNT_W-1:0]        outstanding;
    logic [NUM_LANES-1:0]    lane_free;
    logic [NUM_LANES-1:0]    lane_pending;
    logic [NUM_LANES-1:0]    lane_hit;
    logic [NUM_LANES-1:0]    lane_take;
    logic [NUM_LANES-1:0]    lane_pop;
    logic [HEADER_WIDTH-1:0] lane_header [NUM_LANES];
    logic [SEQ_WIDTH-1:0]    lane_seq    [NUM_LANES];
    logic                    accept;
    logic                    retire;
    logic                    restart_pending;
    logic                    restart_clear;

    assign restart_pending     = (state == ST_DRAIN);
    assign bus.md5_block_ready = reset && !done && !restart_pending && lane_free[disp_ptr];
    assign accept              = bus.md5_block_ready && bus.md5_block_valid;
    assign retire              = lane_pending[ret_ptr];

    // Single-lane builds keep both pointers pinned at zero.
    assign disp_ptr_next = (NUM_LANES == 1) ? '0 : disp_ptr + 1'b1;
    assign ret_ptr_next  = (NUM_LANES == 1) ? '0 : ret_ptr + 1'b1;

    // An idle engine restarts on the spot; otherwise the clear waits for the drain.
    assign restart_clear = ((state == ST_RUN) && restart && (outstanding == '0) && !accept) ||
                           ((state == ST_DRAIN) && (outstanding == '0));

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign lane_take[i] = accept && (disp_ptr == PTR_W'(i));
        assign lane_pop[i]  = retire && (ret_ptr == PTR_W'(i));

        md5_lane #(
            .BLOCK_WIDTH  (BLOCK_WIDTH),
            .HEADER_WIDTH (HEADER_WIDTH),
            .SEQ_WIDTH    (SEQ_WIDTH)
        ) u_lane (
            .clk          (clk),
            .reset        (reset),
            .zero_nibbles (zero_nibbles),
            .take         (lane_take[i]),
            .block        (bus.md5_block_data),
            .seq_in       (seq),
            .pop          (lane_pop[i]),
            .free         (lane_free[i]),
            .pending      (lane_pending[i]),
            .hit          (lane_hit[i]),
            .header       (lane_header[i]),
            .seq          (lane_seq[i])
        );
    end

    // Restart sequencing: hold in DRAIN until every outstanding block has retired.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN:   if (restart && !restart_clear) state <= ST_DRAIN;
                ST_DRAIN: if (restart_clear) state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase
        end
    end

    // Dispatch/retire pointers, occupancy, and the one-shot result report.
    always_ff @(posedge clk) begin
        if (!reset) begin
            disp_ptr         <= '0;
            ret_ptr          <= '0;
            seq              <= '0;
            outstanding      <= '0;
            done             <= 1'b0;
            bus.result_valid <= 1'b0;
            bus.result_data  <= '0;
            bus.result_seq   <= '0;
        end else begin
            bus.result_valid <= 1'b0;
            if (accept) begin
                disp_ptr <= disp_ptr_next;
                seq      <= seq + 1'b1;
            end
            if (retire) begin
                ret_ptr <= ret_ptr_next;
                if (lane_hit[ret_ptr] && !done) begin
                    bus.result_valid <= 1'b1;
                    bus.result_data  <= lane_header[ret_ptr];
                    bus.result_seq   <= lane_seq[ret_ptr];
                    done             <= 1'b1;
                end
            end
            if (accept && !retire) begin
                outstanding <= outstanding + 1'b1;
            end else if (!accept && retire) begin
                outstanding <= outstanding - 1'b1;
            end
            if (restart_clear) begin
                disp_ptr <= '0;
                ret_ptr  <= '0;
                seq      <= '0;
                done     <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_md5_multi_lane_engine.sv
// Scoreboard bench for md5_multi_lane_engine. Each block carries its digest in
// bits [127:0] and its core latency in bits [135:128]; the model decides from
// those which block (in dispatch order) is the first hit and queues the result.
module tb_md5_multi_lane_engine;
    localparam int NUM_LANES    = 4;
    localparam int BLOCK_WIDTH  = 512;
    localparam int HEADER_WIDTH = 128;
    localparam int SEQ_WIDTH    = 4;

    typedef struct packed {
        logic [HEADER_WIDTH-1:0] header;
        logic [SEQ_WIDTH-1:0]    seq;
    } result_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       restart = 1'b0;
    logic [5:0] zero_nibbles = 6'd5;
    logic       done;

    md5_multi_lane_engine_if #(
        .BLOCK_WIDTH (BLOCK_WIDTH), .HEADER_WIDTH (HEADER_WIDTH), .SEQ_WIDTH (SEQ_WIDTH)
    ) bus ();

    md5_multi_lane_engine #(
        .NUM_LANES (NUM_LANES), .BLOCK_WIDTH (BLOCK_WIDTH),
        .HEADER_WIDTH (HEADER_WIDTH), .SEQ_WIDTH (SEQ_WIDTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .zero_nibbles (zero_nibbles),
        .restart      (restart),
        .done         (done),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int      checks = 0;
    int      errors = 0;
    result_t exp_q[$];
    int      results_seen = 0;
    int      last_result_cyc = 0;
    int      epoch_cnt = 0;
    bit      exp_found = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int lead_zeros(input logic [127:0] d);
        int n = 0;
        while (n < 32 && d[127-4*n -: 4] == 4'h0) n++;
        return n;
    endfunction

    function automatic int eff_zn();
        return (zero_nibbles > 6'd32) ? 32 : int'(zero_nibbles);
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Random digest with a nonzero leading digit: never a hit for zero_nibbles >= 1.
    function automatic logic [127:0] rand_miss();
        logic [127:0] d = rand128();
        d[127:124] = 4'($urandom_range(1, 15));
        return d;
    endfunction

    // Random digest with at least five leading zero digits.
    function automatic logic [127:0] rand_hit();
        logic [127:0] d = rand128();
        d[127:108] = 20'h0;
        return d;
    endfunction

    // Monitor: every result pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (bus.result_valid === 1'b1) begin
            result_t e;
            results_seen++;
            last_result_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got seq %0d header %0h, expected no result",
                         bus.result_seq, bus.result_data);
            end else begin
                e = exp_q.pop_front();
                check("result_header", bus.result_data, e.header);
                check("result_seq", bus.result_seq, e.seq);
                check("done_with_result", done, 1'b1);
            end
        end
    end

    // Offer one block; ok=0 when the engine halted (done) before taking it.
    task automatic send(input logic [127:0] hdr, input logic [127:0] dg, input int lat,
                        output bit ok, output int acc);
        int n = 0;
        ok  = 0;
        acc = 0;
        @(negedge clk);
        while (bus.md5_block_ready !== 1'b1 && done !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (done === 1'b1) return;
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ready still %b after %0d cycles, expected 1", bus.md5_block_ready, n);
            return;
        end
        bus.md5_block_valid = 1'b1;
        bus.md5_block_data  = {hdr, 248'h0, 8'(lat), dg};
        @(posedge clk);
        #1;
        bus.md5_block_valid = 1'b0;
        ok  = 1;
        acc = cyc;
        if (!exp_found && lead_zeros(dg) >= eff_zn()) begin
            exp_q.push_back(result_t'{hdr, SEQ_WIDTH'(epoch_cnt)});
            exp_found = 1;
        end
        epoch_cnt++;
    endtask

    task automatic wait_results(input string name, input int base_seen);
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing: %0d results outstanding, expected 0", name, exp_q.size());
        end
        repeat (120) @(negedge clk);
        check({name, "_count"}, 128'(results_seen - base_seen), 128'd1);
        check({name, "_done"}, done, 1'b1);
        check({name, "_ready_low"}, bus.md5_block_ready, 1'b0);
    endtask

    task automatic do_restart();
        int n = 0;
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        epoch_cnt = 0;
        exp_found = 0;
        while (bus.md5_block_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("restart_ready", bus.md5_block_ready, 1'b1);
        check("restart_done_clear", done, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, expected to end", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit           ok;
        int           acc;
        int           base;
        int           acc_q[4];
        int           drain_lb;
        bit           early;
        logic [127:0] hdr;

        // Reset held with valid asserted: nothing may be accepted or reported.
        bus.md5_block_valid = 1'b1;
        bus.md5_block_data  = {128'hdead, 248'h0, 8'd60, 128'h0};
        repeat (3) begin
            @(negedge clk);
            check("reset_ready", bus.md5_block_ready, 1'b0);
            check("reset_result_valid", bus.result_valid, 1'b0);
            check("reset_done", done, 1'b0);
        end
        check("reset_result_data", bus.result_data, 128'h0);
        check("reset_result_seq", bus.result_seq, 128'h0);
        bus.md5_block_valid = 1'b0;
        reset = 1'b1;

        // abcdef609043..050: only the first has five leading zero digits.
        base = results_seen;
        for (int i = 0; i < 8; i++) begin
            int num = 43 + i;
            hdr = {32'h0, "abcdef6090", 8'(8'h30 + num / 10), 8'(8'h30 + num % 10)};
            send(hdr, (i == 0) ? 128'h000001dbbfa3a5c83a2d506429c7b00e : rand_miss(),
                 $urandom_range(60, 80), ok, acc);
            if (!ok) break;
        end
        wait_results("aoc", base);
        do_restart();

        // Lane 2 finishes first and hits; report must wait for seq 0 and 1.
        base = results_seen;
        for (int i = 0; i < 4; i++) begin
            send(rand128(), (i == 2) ? rand_hit() : rand_miss(), (i == 2) ? 20 : 80, ok, acc);
            acc_q[i] = acc;
        end
        wait_results("ooo", base);
        checks++;
        if (last_result_cyc < acc_q[1] + 80) begin
            errors++;
            $display("FAIL ooo_order: result at cycle %0d, expected at or after %0d", last_result_cyc, acc_q[1] + 80);
        end
        do_restart();

        // Hits at seq 1 and 3: only seq 1 is reported, the rest drain silently.
        base = results_seen;
        for (int i = 0; i < 4; i++) begin
            send(rand128(), (i == 1 || i == 3) ? rand_hit() : rand_miss(), $urandom_range(60, 80), ok, acc);
            if (!ok) break;
        end
        wait_results("two_hits", base);
        do_restart();

        // Restart with three blocks outstanding: input stays closed until drained.
        drain_lb = 0;
        for (int i = 0; i < 3; i++) begin
            int lat = $urandom_range(70, 80);
            send(rand128(), rand_miss(), lat, ok, acc);
            if (acc + lat > drain_lb) drain_lb = acc + lat;
        end
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        epoch_cnt = 0;
        exp_found = 0;
        early = 0;
        for (int n = 0; n < 1000 && bus.md5_block_ready !== 1'b1; n++) @(negedge clk);
        if (cyc < drain_lb) early = 1;
        check("drain_ready_held", early, 1'b0);
        check("drain_done_clear", done, 1'b0);
        base = results_seen;
        send(rand128(), rand_hit(), $urandom_range(60, 80), ok, acc);
        wait_results("after_drain", base);
        do_restart();

        // zero_nibbles=0: every digest is a hit, first block reported.
        zero_nibbles = 6'd0;
        base = results_seen;
        for (int i = 0; i < 3; i++) begin
            send(rand128(), rand128(), $urandom_range(60, 80), ok, acc);
            if (!ok) break;
        end
        wait_results("zn0", base);
        do_restart();

        // 20 misses then a hit: 4-bit sequence wraps, hit reported as seq 4.
        zero_nibbles = 6'd5;
        base = results_seen;
        for (int i = 0; i < 21; i++) begin
            send(rand128(), (i == 20) ? rand_hit() : rand_miss(), $urandom_range(60, 80), ok, acc);
            if (!ok) break;
        end
        wait_results("wrap", base);
        do_restart();

        // zero_nibbles above 32 saturates: only an all-zero digest hits.
        zero_nibbles = 6'd40;
        base = results_seen;
        send(rand128(), 128'h1, $urandom_range(60, 80), ok, acc);
        send(rand128(), 128'h0, $urandom_range(60, 80), ok, acc);
        wait_results("zn40", base);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
